// File: rtl/sdiv_seq_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types, constants and helpers for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_N   = 8;
    // Working width of the negate helper; operand widths up to this are supported.
    localparam int c_NEG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [c_NEG_W-1:0] twos_neg(input logic [c_NEG_W-1:0] v);
        return ~v + {{(c_NEG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdiv_seq_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sdiv_seq_param_if
// Brief    : Start/done request and result bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface sdiv_seq_param_if #(
    parameter int N = div_pkg::DIV_N
);
    logic         start;
    logic         signed_mode;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sdiv_seq_param_div_restore_step.sv
`default_nettype none
// ============================================================================
// Module   : div_restore_step
// Brief    : One restoring-division iteration: trial subtract and shift.
// Revision : 1.0 - initial release
// ============================================================================
module div_restore_step #(
    parameter int N = div_pkg::DIV_N
) (
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_dmag,
    output logic [N-1:0] o_acc_next,
    output logic [N-1:0] o_q_next
);
    logic [N:0] w_trial;

    assign w_trial = {i_acc, i_q[N-1]} - {1'b0, i_dmag};

    // o_q_next[0] is the quotient bit produced by this step.
    always_comb begin
        o_acc_next = {i_acc[N-2:0], i_q[N-1]};
        o_q_next   = {i_q[N-2:0], 1'b0};
        if (!w_trial[N]) begin
            o_acc_next = w_trial[N-1:0];
            o_q_next   = {i_q[N-2:0], 1'b1};
        end
    end
endmodule
`default_nettype wire

// File: rtl/sdiv_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : sdiv_seq_param
// Brief    : Self-sequenced signed/unsigned N-bit restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module sdiv_seq_param #(
    parameter int N = div_pkg::DIV_N
) (
    input  logic            clk,
    input  logic            reset,
    sdiv_seq_param_if.slave bus
);
    import div_pkg::*;

    localparam int            CW        = $clog2(N + 1);
    localparam logic [N-1:0]  c_MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] c_ITERS   = CW'(N);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_dmag;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_dbz_pend;
    logic          r_ovf_pend;

    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_accept;
    logic          w_dvd_neg;
    logic          w_dvs_neg;
    logic          w_dvs_zero;
    logic          w_ovf_case;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N-1:0]  w_acc_next;
    logic [N-1:0]  w_q_next;
    logic [N-1:0]  w_quot_fix;
    logic [N-1:0]  w_rem_fix;

    // Operand magnitudes and sign bookkeeping, evaluated for the accepting cycle.
    always_comb begin
        w_dvd_neg  = bus.signed_mode & bus.dividend[N-1];
        w_dvs_neg  = bus.signed_mode & bus.divisor[N-1];
        w_dvs_zero = (bus.divisor == '0);
        w_ovf_case = bus.signed_mode & (bus.dividend == c_MIN_NEG) & (&bus.divisor);
        w_dvd_mag  = w_dvd_neg ? N'(twos_neg(c_NEG_W'(bus.dividend))) : bus.dividend;
        w_dvs_mag  = w_dvs_neg ? N'(twos_neg(c_NEG_W'(bus.divisor)))  : bus.divisor;
    end

    div_restore_step #(
        .N (N)
    ) u_step (
        .i_acc      (r_acc),
        .i_q        (r_q),
        .i_dmag     (r_dmag),
        .o_acc_next (w_acc_next),
        .o_q_next   (w_q_next)
    );

    // Negating a zero remainder yields zero, so no special case is needed.
    always_comb begin
        w_quot_fix = r_sign_q ? N'(twos_neg(c_NEG_W'(r_q)))   : r_q;
        w_rem_fix  = r_sign_r ? N'(twos_neg(c_NEG_W'(r_acc))) : r_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_dvs_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_count == c_ONE) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_dmag     <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sign_q   <= bus.signed_mode & (bus.dividend[N-1] ^ bus.divisor[N-1]);
                r_sign_r   <= w_dvd_neg;
                r_dmag     <= w_dvs_mag;
                r_acc      <= '0;
                r_dbz_pend <= w_dvs_zero;
                r_ovf_pend <= w_ovf_case;
                // A zero divisor reports the untouched dividend as remainder.
                r_q        <= w_dvs_zero ? bus.dividend : w_dvd_mag;
                r_count    <= w_dvs_zero ? '0 : c_ITERS;
            end else if (r_state == CALC) begin
                r_acc   <= w_acc_next;
                r_q     <= w_q_next;
                r_count <= r_count - c_ONE;
            end else if (r_state == FIX) begin
                r_done <= 1'b1;
                if (r_dbz_pend) begin
                    r_quot <= '1;
                    r_rem  <= r_q;
                    r_dbz  <= 1'b1;
                    r_ovf  <= 1'b0;
                end else begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                    r_dbz  <= 1'b0;
                    r_ovf  <= r_ovf_pend;
                end
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sdiv_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdiv_seq_param
// Brief    : Directed self-checking bench for sdiv_seq_param at N = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdiv_seq_param;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sdiv_seq_param_if #(.N(8)) bus ();

    sdiv_seq_param #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic sm, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.dividend    = a;
        bus.divisor     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Edges counted until done is seen; busy counted from the accepting edge.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = bus.busy ? 1 : 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) break;
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input int elat);
        int cyc;
        int bc;
        start_op(sm, a, b);
        wait_done(cyc, bc);
        check({tag, " latency"}, cyc, elat);
        check({tag, " busy_cycles"}, bc, elat);
        check({tag, " quotient"}, {24'd0, bus.quotient}, {24'd0, eq});
        check({tag, " remainder"}, {24'd0, bus.remainder}, {24'd0, er});
        check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eovf});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " quotient_held"}, {24'd0, bus.quotient}, {24'd0, eq});
    endtask

    initial begin
        int cyc;
        int bc;
        int done_seen;
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.dividend    = 8'h00;
        bus.divisor     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset quotient", {24'd0, bus.quotient}, 32'd0);
        check("reset remainder", {24'd0, bus.remainder}, 32'd0);
        check("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check("reset ovf", {31'd0, bus.overflow}, 32'd0);
        reset = 1'b0;

        do_op("u100_7",    1'b0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9);
        do_op("s-100_7",   1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9);
        do_op("s100_-7",   1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9);
        do_op("s-100_-7",  1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 9);
        do_op("s_ovf",     1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9);
        do_op("u80_FF",    1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 9);
        do_op("u_dbz",     1'b0, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 1'b0, 1);
        do_op("s_dbz_neg", 1'b1, 8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, 1'b0, 1);
        do_op("s-14_7",    1'b1, 8'hF2, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b0, 9);
        do_op("u5_9",      1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 9);
        do_op("uFF_1",     1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9);

        // Start and operand changes during CALC must be ignored.
        start_op(1'b0, 8'h64, 8'h07);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.start       = 1'b1;
        bus.signed_mode = 1'b1;
        bus.dividend    = 8'h05;
        bus.divisor     = 8'h00;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'hAA;
        bus.divisor  = 8'h03;
        wait_done(cyc, bc);
        check("ignore latency", cyc, 6);
        check("ignore quotient", {24'd0, bus.quotient}, 32'h0E);
        check("ignore remainder", {24'd0, bus.remainder}, 32'h02);
        check("ignore dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        check("ignore idle", {31'd0, bus.busy}, 32'd0);

        // New start accepted in the same cycle done is high.
        start_op(1'b0, 8'h64, 8'h07);
        wait_done(cyc, bc);
        check("b2b first latency", cyc, 9);
        check("b2b first quotient", {24'd0, bus.quotient}, 32'h0E);
        bus.start       = 1'b1;
        bus.signed_mode = 1'b1;
        bus.dividend    = 8'h9C;
        bus.divisor     = 8'hF9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b second busy", {31'd0, bus.busy}, 32'd1);
        check("b2b done dropped", {31'd0, bus.done}, 32'd0);
        wait_done(cyc, bc);
        check("b2b second latency", cyc, 9);
        check("b2b second quotient", {24'd0, bus.quotient}, 32'h0E);
        check("b2b second remainder", {24'd0, bus.remainder}, 32'hFE);

        // Reset in the middle of CALC aborts with no done.
        start_op(1'b0, 8'h64, 8'h07);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst quotient", {24'd0, bus.quotient}, 32'd0);
        check("midrst remainder", {24'd0, bus.remainder}, 32'd0);
        check("midrst dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check("midrst ovf", {31'd0, bus.overflow}, 32'd0);
        reset     = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("midrst no_done", done_seen, 0);

        do_op("u200_3", 1'b0, 8'hC8, 8'h03, 8'h42, 8'h02, 1'b0, 1'b0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
